fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 73 +++++++
 tb/tb_fifo_wr_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter multiplexing requesters onto a FIFO write port
module fifo_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full,
  output logic                          w_en,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);
  localparam int ID_W = $clog2(NUM_REQ);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nx;
  logic [ID_W-1:0] owner, owner_nx, rr_ptr, rr_ptr_nx, pick, idx, own_inc, sel;
  logic [3:0] beat_cnt, beat_cnt_nx;
  logic own_valid, beat, done;
  always_comb begin
    pick = rr_ptr;
    idx = rr_ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (req_valid[idx]) pick = idx;
    end
  end
  assign own_inc = (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  assign own_valid = req_valid[owner];
  assign beat = (state == GRANT) && own_valid && !full;
  assign done = beat && (beat_cnt + 4'd1 == 4'(MAX_BURST));
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    rr_ptr_nx = rr_ptr;
    beat_cnt_nx = beat_cnt;
    if (state == IDLE) begin
      if (|req_valid) begin
        state_nx = GRANT;
        owner_nx = pick;
        beat_cnt_nx = '0;
      end
    end else if (!own_valid || done) begin
      state_nx = IDLE;
      rr_ptr_nx = own_inc;
    end else if (beat) begin
      beat_cnt_nx = beat_cnt + 4'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      rr_ptr <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      rr_ptr <= rr_ptr_nx;
      beat_cnt <= beat_cnt_nx;
    end
  end
  assign busy = (state == GRANT) && !rst;
  assign w_en = beat && !rst;
  assign sel = rst ? '0 : owner;
  assign grant_id = sel;
  assign req_ready = (busy && !full) ? NUM_REQ'(1) << owner : '0;
  assign data_in = req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and randomized self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
  logic clk, rst, full, w_en, busy;
  logic [3:0] req_valid, req_ready;
  logic [31:0] req_data;
  logic [7:0] data_in;
  logic [1:0] grant_id;
  int total = 0;
  int bad = 0;
  int sent;
  logic [15:0] wm, bm, fm;
  logic [7:0] seq [4];
  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .full(full), .w_en(w_en), .data_in(data_in), .grant_id(grant_id), .busy(busy)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic rst_pulse;
    rst = 1;
    req_valid = '0;
    full = 0;
    nxt;
    rst = 0;
  endtask
  initial begin
    rst = 1;
    full = 0;
    req_valid = 4'b1111;
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    nxt;
    nxt;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_wen", w_en, 0);
    chk("rst_rdy", req_ready, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_din", data_in, 8'hA0);
    rst = 0;
    for (int g = 0; g < 5; g++) begin
      #1;
      chk("a_idle_busy", busy, 0);
      chk("a_idle_wen", w_en, 0);
      nxt;
      for (int b = 0; b < 4; b++) begin
        #1;
        chk("a_gid", grant_id, g % 4);
        chk("a_wen", w_en, 1);
        chk("a_rdy", req_ready, 1 << (g % 4));
        chk("a_data", data_in, 8'hA0 + g % 4);
        nxt;
      end
    end
    rst_pulse;
    sent = 0;
    wm = 16'b0011_0111_1011_1100;
    bm = 16'b0111_0111_1011_1100;
    for (int c = 1; c <= 15; c++) begin
      req_valid = (sent < 10) ? 4'b0100 : 4'b0000;
      req_data[16 +: 8] = 8'h10 + 8'(sent);
      #1;
      chk("b_wen", w_en, wm[c]);
      chk("b_busy", busy, bm[c]);
      if (bm[c]) chk("b_gid", grant_id, 2);
      if (wm[c]) chk("b_data", data_in, 8'h10 + sent);
      if (w_en) sent++;
      nxt;
    end
    chk("b_sent", sent, 10);
    rst_pulse;
    wm = 16'b0000_0001_1000_1100;
    bm = 16'b0000_0001_1111_1100;
    fm = 16'b0000_0000_0111_0000;
    for (int c = 1; c <= 9; c++) begin
      req_valid = 4'b0010;
      full = fm[c];
      #1;
      chk("c_wen", w_en, wm[c]);
      chk("c_busy", busy, bm[c]);
      chk("c_rdy", req_ready, wm[c] ? 4'b0010 : 4'b0000);
      nxt;
    end
    full = 0;
    rst_pulse;
    req_valid = 4'b1000;
    #1;
    chk("d_idle", busy, 0);
    nxt;
    #1;
    chk("d_gid", grant_id, 3);
    chk("d_wen", w_en, 1);
    nxt;
    req_valid = 4'b0111;
    #1;
    chk("d_drop_busy", busy, 1);
    chk("d_drop_wen", w_en, 0);
    chk("d_drop_rdy", req_ready, 4'b1000);
    nxt;
    #1;
    chk("d_rel", busy, 0);
    nxt;
    #1;
    chk("d_next_gid", grant_id, 0);
    chk("d_next_wen", w_en, 1);
    nxt;
    req_valid = 4'b0100;
    #1;
    chk("e_drop_wen", w_en, 0);
    nxt;
    #1;
    chk("e_idle", busy, 0);
    nxt;
    #1;
    chk("e_gid", grant_id, 2);
    chk("e_b1", w_en, 1);
    nxt;
    #1;
    chk("e_b2", w_en, 1);
    nxt;
    rst = 1;
    #1;
    chk("e_rst_wen", w_en, 0);
    chk("e_rst_busy", busy, 0);
    chk("e_rst_rdy", req_ready, 0);
    chk("e_rst_gid", grant_id, 0);
    nxt;
    rst = 0;
    req_valid = 4'b1111;
    #1;
    chk("e_post_idle", busy, 0);
    nxt;
    #1;
    chk("e_post_gid", grant_id, 0);
    chk("e_post_wen", w_en, 1);
    rst_pulse;
    for (int i = 0; i < 4; i++) seq[i] = 8'(i * 64);
    for (int n = 0; n < 3000; n++) begin
      req_valid = 4'($urandom);
      full = ($urandom_range(3) == 0);
      for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = seq[i];
      #1;
      chk("r_onehot", $countones(req_ready) <= 1, 1);
      chk("r_full", w_en && full, 0);
      chk("r_hs", w_en, busy && req_valid[grant_id] && req_ready[grant_id]);
      chk("r_din", data_in, seq[grant_id]);
      if (w_en) seq[grant_id] = seq[grant_id] + 8'd1;
      nxt;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
